// File: rtl/sram_responder.sv
// Single-request responder between the LC-3b MAR/MDR bus and an async 16-bit SRAM.
// Runs one read or write with a programmable strobe width and acknowledges via a four-phase R handshake.
module sram_responder #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [19:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        R,
    output logic [19:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        CE_N,
    output logic        OE_N,
    output logic        WE_N,
    output logic        UB_N,
    output logic        LB_N
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_CAP,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wbuf_q, wbuf_d;
    logic [15:0] rdata_q, rdata_d;
    logic        r_q, r_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        be_n_q, be_n_d;
    logic        dq_oe_q, dq_oe_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (wr) begin
                    addr_d  = addr;
                    wbuf_d  = wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = WR_SETUP;
                end else if (rd) begin
                    addr_d  = addr;
                    cnt_d   = WAIT_INIT;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RD_CAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_CAP: begin
                rdata_d = sram_dq;
                state_d = DONE;
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: begin
                if (cnt_q <= 4'd1) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_HOLD: state_d = DONE;
            DONE: begin
                if (!rd && !wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin flops are decoded from the next state so they line up with it
        ce_n_d  = !(state_d inside {RD_WAIT, RD_CAP, WR_SETUP,
                                    WR_PULSE, WR_HOLD});
        oe_n_d  = !(state_d inside {RD_WAIT, RD_CAP});
        we_n_d  = (state_d != WR_PULSE);
        be_n_d  = ce_n_d;
        dq_oe_d = (state_d inside {WR_SETUP, WR_PULSE, WR_HOLD});
        r_d     = (state_q == DONE) && (rd || wr);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
            r_q     <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            rdata_q <= rdata_d;
            r_q     <= r_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    assign sram_dq   = dq_oe_q ? wbuf_q : 16'bz;
    assign rdata     = rdata_q;
    assign R         = r_q;
    assign sram_addr = addr_q;
    assign CE_N      = ce_n_q;
    assign OE_N      = oe_n_q;
    assign WE_N      = we_n_q;
    assign UB_N      = be_n_q;
    assign LB_N      = be_n_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: random and directed accesses against
// an async SRAM device model and a word-level reference memory.
module tb_sram_responder;

    localparam int W = 2;

    logic        Clk;
    logic        Reset;
    logic        rd;
    logic        wr;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        R;
    logic [19:0] sram_addr;
    wire  [15:0] dq;
    logic        CE_N, OE_N, WE_N, UB_N, LB_N;

    sram_responder #(.WAIT_CYCLES(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .R        (R),
        .sram_addr(sram_addr),
        .sram_dq  (dq),
        .CE_N     (CE_N),
        .OE_N     (OE_N),
        .WE_N     (WE_N),
        .UB_N     (UB_N),
        .LB_N     (LB_N)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] init_val(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], 12'h5A3};
    endfunction

    // Asynchronous SRAM device: drives dq while read-enabled, latches on WE_N rise
    logic [15:0] dev_mem [logic [19:0]];
    logic [15:0] dev_rd;

    assign dq = (!CE_N && !OE_N && WE_N) ? dev_rd : 16'bz;

    always @(OE_N or sram_addr) begin
        dev_rd = dev_mem.exists(sram_addr) ? dev_mem[sram_addr]
                                           : init_val(sram_addr);
    end

    always @(posedge WE_N) begin
        if (!CE_N) dev_mem[sram_addr] = dq;
    end

    // Reference model: word memory plus last read value
    logic [15:0] ref_mem [logic [19:0]];
    logic [15:0] last_rd;

    typedef struct {
        bit          is_wr;
        logic [15:0] exp_rdata;
        int          issue;
        int          exp_lat;
        int          exp_oe;
        int          exp_we;
    } exp_t;

    exp_t sb[$];

    int n_chk;
    int n_pass;
    int cyc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Monitor: counts strobe-low cycles and checks each R rise against the scoreboard
    int   oe_cnt;
    int   we_cnt;
    logic r_prev;

    initial begin
        cyc    = 0;
        oe_cnt = 0;
        we_cnt = 0;
        r_prev = 1'b0;
        forever begin
            exp_t e;
            @(posedge Clk);
            cyc++;
            #1;
            if (Reset) begin
                oe_cnt = 0;
                we_cnt = 0;
                r_prev = 1'b0;
            end else begin
                if (!OE_N) oe_cnt++;
                if (!WE_N) we_cnt++;
                if (R && !r_prev) begin
                    if (sb.size() == 0) begin
                        chk("spurious_r", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("latency", cyc - e.issue, e.exp_lat);
                        chk("rdata", {16'h0, rdata}, {16'h0, e.exp_rdata});
                        chk("oe_cycles", oe_cnt, e.exp_oe);
                        chk("we_cycles", we_cnt, e.exp_we);
                    end
                    oe_cnt = 0;
                    we_cnt = 0;
                end
                r_prev = R;
            end
        end
    end

    task automatic finish_now();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    task automatic do_access(input bit do_rd, input bit do_wr,
                             input logic [19:0] a, input logic [15:0] d,
                             input int hold);
        exp_t e;
        int   n;
        @(negedge Clk);
        rd    = do_rd;
        wr    = do_wr;
        addr  = a;
        wdata = d;
        e.issue = cyc + 1;
        if (do_wr) begin
            ref_mem[a]  = d;
            e.is_wr     = 1'b1;
            e.exp_rdata = last_rd;
            e.exp_lat   = W + 3;
            e.exp_oe    = 0;
            e.exp_we    = W;
        end else begin
            last_rd     = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
            e.is_wr     = 1'b0;
            e.exp_rdata = last_rd;
            e.exp_lat   = W + 2;
            e.exp_oe    = W + 1;
            e.exp_we    = 0;
        end
        sb.push_back(e);
        @(negedge Clk);
        addr  = 20'($urandom);
        wdata = 16'($urandom);
        n = 0;
        while (!R && n < 40) begin
            @(negedge Clk);
            n++;
        end
        if (!R) begin
            n_chk++;
            $display("FAIL r_timeout: R still 0 after %0d cycles", n);
            finish_now();
        end
        repeat (hold) @(negedge Clk);
        if (hold > 0) chk("r_held", {31'h0, R}, 32'd1);
        rd = 1'b0;
        wr = 1'b0;
        @(posedge Clk);
        #1;
        chk("r_fall", {31'h0, R}, 32'd0);
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_pins"}, {27'h0, CE_N, OE_N, WE_N, UB_N, LB_N}, 32'h1F);
        chk({tag, "_r"}, {31'h0, R}, 32'd0);
        chk({tag, "_rdata"}, {16'h0, rdata}, 32'd0);
    endtask

    initial begin
        int n;
        n_chk   = 0;
        n_pass  = 0;
        last_rd = 16'h0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        wdata   = '0;
        Reset   = 1'b0;
        #2 Reset = 1'b1;
        #1;
        chk_idle_pins("reset");
        chk("reset_addr", {12'h0, sram_addr}, 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        do_access(1'b0, 1'b1, 20'h00012, 16'hBEEF, 0);
        do_access(1'b1, 1'b0, 20'h00012, 16'h0000, 0);
        do_access(1'b1, 1'b0, 20'h00012, 16'h0000, 6);
        do_access(1'b1, 1'b1, 20'h00003, 16'h1234, 0);
        do_access(1'b1, 1'b0, 20'h00003, 16'h0000, 1);
        do_access(1'b1, 1'b0, 20'hFFFFF, 16'h0000, 0);

        // Reset pulse between clock edges while idle
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk_idle_pins("idle_reset");
        @(negedge Clk);
        Reset   = 1'b0;
        last_rd = 16'h0;

        do_access(1'b1, 1'b0, 20'h00012, 16'h0000, 0);

        // Reset during the write pulse
        @(negedge Clk);
        wr    = 1'b1;
        addr  = 20'h00040;
        wdata = 16'hDEAD;
        n = 0;
        do begin
            @(posedge Clk);
            #1;
            n++;
        end while (WE_N && n < 20);
        chk("we_pulse_seen", {31'h0, WE_N}, 32'd0);
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        wr    = 1'b0;
        #1;
        chk_idle_pins("write_reset");
        @(negedge Clk);
        Reset   = 1'b0;
        last_rd = 16'h0;

        do_access(1'b1, 1'b0, 20'h00020, 16'h0000, 0);

        for (int i = 0; i < 60; i++) begin
            int          kind;
            int          idx;
            logic [19:0] a;
            kind = $urandom_range(0, 3);
            idx  = $urandom_range(0, 7);
            a    = (idx == 7) ? 20'hFFFFF : 20'(idx);
            do_access(kind != 1, kind == 1 || kind == 2, a,
                      16'($urandom), $urandom_range(0, 3));
        end

        repeat (5) @(negedge Clk);
        chk("sb_empty", sb.size(), 32'd0);
        finish_now();
    end

endmodule
